// File: rtl/cla_pkg.sv
// Shared types and helpers for the carry-lookahead carry sequencer.
// Pure declarations; no timing of its own.
// No flow control of its own; used by the sequencer and its G/P cell.
package cla_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_e;

  // Default group size handled by the shared G/P cell.
  localparam int SLICE_DEFAULT = 4;

  // Width of the slice index counter.
  // A single-slice word still needs a one-bit index.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cla_gp_slice.sv
// Group generate/propagate cell for one SLICE-bit operand slice.
// Purely combinational, zero cycles.
// No flow control; the sequencer decides when its output is used.
module cla_gp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             g_o,
  output logic             p_o
);

  logic [SLICE-1:0] bit_g;
  logic [SLICE-1:0] bit_p;
  logic             term;

  // Inclusive-OR propagate keeps the group P usable for carry chaining.
  assign bit_g = a_i & b_i;
  assign bit_p = a_i | b_i;
  assign p_o   = &bit_p;

  // Lookahead generate: bit i's generate reaches the slice top only if every higher bit propagates.
  always_comb begin
    g_o  = 1'b0;
    term = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      term = bit_g[i];
      for (int j = i + 1; j < SLICE; j++) begin
        term = term & bit_p[j];
      end
      g_o = g_o | term;
    end
  end

endmodule

// File: rtl/cla_carry_sequencer.sv
// Walks one shared G/P cell across WIDTH/SLICE slices to form cout, group G and group P.
// Latency: accept at edge k, out_valid rises after edge k+NSLICE; back-to-back period NSLICE+2.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready.
module cla_carry_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cout,
  output logic             grp_g,
  output logic             grp_p
);

  localparam int              NSLICE   = WIDTH / SLICE;
  localparam int              IW       = idx_width(NSLICE);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NSLICE - 1);

  cla_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic             gacc_q;
  logic             pacc_q;
  logic [IW-1:0]    idx_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [SLICE-1:0] a_slc;
  logic [SLICE-1:0] b_slc;
  logic             slc_g;
  logic             slc_p;

  logic             c_d;
  logic             gacc_d;
  logic             pacc_d;
  logic [IW-1:0]    idx_d;
  logic             last_slc;

  // Steer the captured operand slice picked by idx into the shared cell.
  always_comb begin
    a_slc = '0;
    b_slc = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (idx_q == IW'(s)) begin
        a_slc = a_q[s*SLICE +: SLICE];
        b_slc = b_q[s*SLICE +: SLICE];
      end
    end
  end

  cla_gp_slice #(
    .SLICE (SLICE)
  ) u_gp_slice (
    .a_i (a_slc),
    .b_i (b_slc),
    .g_o (slc_g),
    .p_o (slc_p)
  );

  // Fold the current slice's G/P into the carry and the running group terms.
  always_comb begin
    c_d      = slc_g | (slc_p & c_q);
    gacc_d   = slc_g | (slc_p & gacc_q);
    pacc_d   = pacc_q & slc_p;
    idx_d    = idx_q + IW'(1);
    last_slc = (idx_q == LAST_IDX);
  end

  // Control FSM: capture in IDLE, one slice per cycle in RUN, hold result in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      gacc_q      <= 1'b0;
      pacc_q      <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            c_q        <= cin;
            gacc_q     <= 1'b0;
            pacc_q     <= 1'b1;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          c_q    <= c_d;
          gacc_q <= gacc_d;
          pacc_q <= pacc_d;
          // Hold idx on the top slice so it never wraps.
          if (last_slc) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          idx_q       <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign cout      = c_q;
  assign grp_g     = gacc_q;
  assign grp_p     = pacc_q;

endmodule

// File: tb/tb_cla_carry_sequencer.sv
// Self-checking bench: directed and random operands against an arithmetic reference.
// Checks latency, handshake, hold stability, reset abort and back-to-back throughput.
// Drives out_ready low/high to exercise result backpressure.
module tb_cla_carry_sequencer;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
  } op_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic             cout;
  logic             grp_g;
  logic             grp_p;

  int n_cmp = 0;
  int n_bad = 0;

  cla_carry_sequencer #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cout      (cout),
    .grp_g     (grp_g),
    .grp_p     (grp_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: cout is the true carry of a+b+cin, group G the carry of a+b, group P all bits propagate.
  function automatic logic [2:0] ref_res(input op_t op);
    logic [WIDTH:0] s_c;
    logic [WIDTH:0] s_0;
    s_c = {1'b0, op.a} + {1'b0, op.b} + {{WIDTH{1'b0}}, op.c};
    s_0 = {1'b0, op.a} + {1'b0, op.b};
    return {s_c[WIDTH], s_0[WIDTH], &(op.a | op.b)};
  endfunction

  // One full transaction with latency, hold-stability and release checks.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input int hold, input string tag);
    op_t        op;
    logic [2:0] exp;
    int         n;
    op.a = ta;
    op.b = tb;
    op.c = tc;
    exp  = ref_res(op);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a         = ta;
    b         = tb;
    cin       = tc;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    n = 0;
    while (!out_valid && n < 20) begin
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom);
      in_valid = 1'($urandom);
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(NSLICE));
    chk({tag, "_result"}, {29'd0, cout, grp_g, grp_p}, {29'd0, exp});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom);
      step();
      chk({tag, "_hold"}, {27'd0, out_valid, in_ready, cout, grp_g, grp_p},
          {27'd0, 1'b1, 1'b0, exp});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk({tag, "_release"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t        q[$];
    op_t        sets[2];
    op_t        got_op;
    logic [2:0] exp;
    int         nres;
    int         last;
    int         sel;
    logic       seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    step();
    step();
    chk("reset_state", {27'd0, in_ready, out_valid, cout, grp_g, grp_p}, 32'b10000);
    rst_n = 1'b1;
    step();

    // Directed cases.
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, "ffff_p1");
    run_op(16'h7FFF, 16'h0000, 1'b1, 0, "7fff_c1");
    run_op(16'h8000, 16'h8000, 1'b0, 0, "msb_gen");
    run_op(16'h0000, 16'h0000, 1'b1, 0, "zero_c1");
    run_op(16'hFFFF, 16'h0000, 1'b1, 6, "hold6");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 2, "all_ones");

    // Random operands with random backpressure.
    for (int i = 0; i < 30; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    // Reset during the second RUN cycle drops the pending result.
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_run_state", {27'd0, in_ready, out_valid, cout, grp_g, grp_p}, 32'b10000);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | out_valid;
    end
    chk("rst_run_no_stale", 32'(seen), 32'd0);
    out_ready = 1'b0;

    // Reset while holding a result in DONE.
    a        = 16'h8000;
    b        = 16'h8000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < NSLICE; i++) step();
    chk("done_reached", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst_done_state", {27'd0, in_ready, out_valid, cout, grp_g, grp_p}, 32'b10000);
    rst_n = 1'b1;
    step();

    // Back-to-back with in_valid and out_ready held high, alternating operand sets.
    sets[0].a = 16'hFFFF; sets[0].b = 16'h0001; sets[0].c = 1'b0;
    sets[1].a = 16'h7FFF; sets[1].b = 16'h0000; sets[1].c = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    nres      = 0;
    last      = -1;
    sel       = 0;
    for (int cyc = 0; cyc < 150 && nres < 8; cyc++) begin
      if (in_ready) begin
        a   = sets[sel].a;
        b   = sets[sel].b;
        cin = sets[sel].c;
        q.push_back(sets[sel]);
        sel = 1 - sel;
      end else begin
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom);
      end
      step();
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("b2b_unexpected", 32'd1, 32'd0);
        end else begin
          got_op = q.pop_front();
          exp    = ref_res(got_op);
          chk("b2b_result", {29'd0, cout, grp_g, grp_p}, {29'd0, exp});
        end
        if (last >= 0) chk("b2b_period", 32'(cyc - last), 32'(NSLICE + 2));
        last = cyc;
        nres++;
      end
    end
    chk("b2b_count", 32'(nres), 32'd8);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_carry_sequencer.md
Name: cla_carry_sequencer

Overview:
- Multi-cycle carry/group-generate engine for wide operands.
- Evaluates one SLICE-bit carry-lookahead group generate/propagate cell per cycle, walking LSB to MSB slices of a WIDTH-bit operand pair.
- Produces the final carry-out and the overall group G/P.
- Sits beside the combinational adder slices and sequences the shared 4-bit G/P cell, so a single cell serves the whole word.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand width; must be a multiple of SLICE and >= SLICE.
- SLICE, 4, bits per group G/P evaluation.
- NSLICE, WIDTH/SLICE, derived slice count; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- cout  output  1  carry-out of a+b+cin.
- grp_g  output  1  overall group generate; cin ignored.
- grp_p  output  1  overall group propagate.

Behaviour:
- Bit terms: g_i = a_i & b_i, p_i = a_i | b_i (inclusive-OR propagate).
- Slice G = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0, generalised to SLICE bits. Slice P = AND of its p_i.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture a, b into operand registers, carry register c<=cin, Gacc<=0, Pacc<=1, slice index idx<=0. Go to RUN.
  - RUN: in_ready=0. Each cycle evaluate slice idx from the captured operands:
    - c<=G|P&c
    - Gacc<=G|P&Gacc
    - Pacc<=Pacc&P
    - idx<=idx+1
  - RUN exit: after the cycle with idx==NSLICE-1, go to DONE. idx never wraps inside RUN.
  - DONE: out_valid=1; cout=c, grp_g=Gacc, grp_p=Pacc, all held stable while out_ready=0. On out_ready, go to IDLE.
- Latency: accept at edge k; out_valid rises after edge k+NSLICE.
- Back-to-back period with out_ready tied high: NSLICE+2 cycles.
- in_ready is asserted only in IDLE. in_valid outside IDLE is ignored; changes to a, b or cin after capture have no effect.
- Outputs are registered or decoded from state; no combinational path from in_valid or out_ready to any output.
- Reset values: state=IDLE, in_ready=1, out_valid=0, cout=0, grp_g=0, grp_p=0, idx=0.
- Reset asserted mid-RUN or in DONE:
  - The next edge forces IDLE and clears all state.
  - The pending result is discarded and never presented.
- Reset takes priority over any handshake in the same cycle.
- WIDTH==SLICE: RUN lasts exactly one cycle.

Decomposition:
- Shared package cla_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - SLICE_DEFAULT=4;
  - a function computing idx width as clog2(NSLICE), minimum 1.
- One combinational sub-module, cla_gp_slice: SLICE-bit a/b in, slice G/P out. Instantiated once and fed by an idx-selected operand slice.

Test Plan (WIDTH=16):
- a=16'hFFFF, b=16'h0001, cin=0 -> after 5 cycles out_valid=1, cout=1, grp_g=1, grp_p=1.
- a=16'h7FFF, b=16'h0000, cin=1 -> cout=0, grp_g=0, grp_p=0.
- a=16'h8000, b=16'h8000, cin=0 -> cout=1, grp_g=1, grp_p=0. Then a=16'h0000, b=16'h0000, cin=1 -> cout=0, grp_g=0, grp_p=0.
- Hold out_ready=0 for 6 cycles in DONE -> out_valid and outputs stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- rst_n=0 for one cycle during the 2nd RUN cycle -> next cycle state IDLE, in_ready=1, out_valid=0; no stale result ever appears.
- in_valid held high, out_ready=1, alternating operand sets -> results every 6 cycles, each matching a golden (a+b+cin)>>16; changing a, b during RUN has no effect.
